// File: rtl/sim_phase_pkg.sv
// Shared types for the simulation-phase controller: phase and finish-cause
// encodings plus a width helper for small saturating counters.
package sim_phase_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RESET = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic [CAUSE_W-1:0] {
    NONE    = 2'd0,
    TIMEOUT = 2'd1,
    WDOG    = 2'd2,
    EXT     = 2'd3
  } cause_e;

  // Bits needed to hold values 0..max_val (at least 1).
  function automatic int unsigned bits_for(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while (w < 64 && ((64'd1 << w) <= 64'(max_val))) w++;
    return w;
  endfunction

endpackage

// File: rtl/sim_phase_wdog.sv
// Activity watchdog: idle counter that saturates at IDLE_LIMIT and flags
// expiry. A zero limit disables the watchdog.
module sim_phase_wdog #(
  parameter int unsigned IDLE_LIMIT = 0,
  parameter int unsigned W          = 1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [W-1:0] LIMIT = W'(IDLE_LIMIT);

  logic [W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = idle_q;
    if (clear_i)
      idle_d = '0;
    else if (inc_i && (idle_q != LIMIT))
      idle_d = idle_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) idle_q <= '0;
    else          idle_q <= idle_d;
  end

  assign expired_o = (IDLE_LIMIT != 0) && (idle_q == LIMIT);

endmodule

// File: rtl/sim_phase_ctrl.sv
// Simulation-phase controller: cycle counter, staggered reset release,
// timeout / watchdog / external triggers and a drain handshake before finish.
module sim_phase_ctrl
  import sim_phase_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned N_RST        = 4,
  parameter int unsigned RST_BASE     = 5,
  parameter int unsigned RST_STAGGER  = 2,
  parameter int unsigned TIMEOUT_INIT = 10,
  parameter int unsigned TICK_FREQ    = 1000,
  parameter int unsigned IDLE_LIMIT   = 0,
  parameter int unsigned DRAIN_MAX    = 16
) (
  input  logic               sim_phase_ctrl_clk_ip,
  input  logic               sim_phase_ctrl_rst_n_ip,
  input  logic               sim_phase_ctrl_cfg_we_ip,
  input  logic [CNT_W-1:0]   sim_phase_ctrl_cfg_timeout_ip,
  input  logic               sim_phase_ctrl_activity_ip,
  input  logic               sim_phase_ctrl_finish_req_ip,
  input  logic               sim_phase_ctrl_drain_ack_ip,
  output logic [N_RST-1:0]   sim_phase_ctrl_rst_op,
  output logic [CNT_W-1:0]   sim_phase_ctrl_cycles_op,
  output logic               sim_phase_ctrl_tick_op,
  output logic               sim_phase_ctrl_drain_req_op,
  output logic               sim_phase_ctrl_finish_op,
  output logic [CAUSE_W-1:0] sim_phase_ctrl_cause_op,
  output logic [STATE_W-1:0] sim_phase_ctrl_state_op
);

  // Compare width wide enough for both the counter and 32-bit parameters.
  localparam int unsigned CMP_W  = ((CNT_W > 32) ? CNT_W : 32) + 1;
  localparam int unsigned DCNT_W = bits_for(DRAIN_MAX);
  localparam int unsigned WDOG_W = bits_for(IDLE_LIMIT);
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'((DRAIN_MAX == 0) ? 0 : DRAIN_MAX - 1);
  localparam logic [CMP_W-1:0]  TICK_DIV   = CMP_W'((TICK_FREQ == 0) ? 1 : TICK_FREQ);

  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [CNT_W-1:0]  timeout_q;
  logic [N_RST-1:0]  rst_q, rst_d;
  logic              tick_q, tick_d;
  logic              drain_req_q, finish_q;
  logic [DCNT_W-1:0] drain_cnt_q;
  state_e            state_q;
  cause_e            cause_q;
  logic              wdog_expired;

  assign cycles_d = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);

  // Outputs are registered from next-cycle values so they line up with cycles_op.
  for (genvar gi = 0; gi < N_RST; gi++) begin : g_rst
    localparam logic [CMP_W-1:0] REL = CMP_W'(RST_BASE) + CMP_W'(gi) * CMP_W'(RST_STAGGER);
    assign rst_d[gi] = CMP_W'(cycles_d) < REL;
  end

  assign tick_d = (TICK_FREQ != 0) && (cycles_d != '0) &&
                  ((CMP_W'(cycles_d) % TICK_DIV) == '0);

  sim_phase_wdog #(
    .IDLE_LIMIT (IDLE_LIMIT),
    .W          (WDOG_W)
  ) u_wdog (
    .clk_i     (sim_phase_ctrl_clk_ip),
    .rst_n_i   (sim_phase_ctrl_rst_n_ip),
    .clear_i   (sim_phase_ctrl_activity_ip || (state_q == RESET)),
    .inc_i     (state_q == RUN),
    .expired_o (wdog_expired)
  );

  always_ff @(posedge sim_phase_ctrl_clk_ip or negedge sim_phase_ctrl_rst_n_ip) begin
    if (!sim_phase_ctrl_rst_n_ip) begin
      cycles_q    <= '0;
      timeout_q   <= CNT_W'(TIMEOUT_INIT);
      rst_q       <= '1;
      tick_q      <= 1'b0;
      drain_req_q <= 1'b0;
      finish_q    <= 1'b0;
      drain_cnt_q <= '0;
      state_q     <= RESET;
      cause_q     <= NONE;
    end else begin
      cycles_q <= cycles_d;
      rst_q    <= rst_d;
      tick_q   <= tick_d;
      if (sim_phase_ctrl_cfg_we_ip && ((state_q == RESET) || (state_q == RUN)))
        timeout_q <= sim_phase_ctrl_cfg_timeout_ip;
      case (state_q)
        RESET: if (rst_q == '0) state_q <= RUN;
        RUN: begin
          if (sim_phase_ctrl_finish_req_ip || wdog_expired || (cycles_q > timeout_q)) begin
            state_q     <= DRAIN;
            drain_req_q <= 1'b1;
            drain_cnt_q <= '0;
            if (sim_phase_ctrl_finish_req_ip) cause_q <= EXT;
            else if (wdog_expired)            cause_q <= WDOG;
            else                              cause_q <= TIMEOUT;
          end
        end
        DRAIN: begin
          if (sim_phase_ctrl_drain_ack_ip || (drain_cnt_q == DRAIN_LAST)) begin
            state_q     <= DONE;
            drain_req_q <= 1'b0;
            finish_q    <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DCNT_W'(1);
          end
        end
        DONE: ;
        default: state_q <= RESET;
      endcase
    end
  end

  assign sim_phase_ctrl_rst_op       = rst_q;
  assign sim_phase_ctrl_cycles_op    = cycles_q;
  assign sim_phase_ctrl_tick_op      = tick_q;
  assign sim_phase_ctrl_drain_req_op = drain_req_q;
  assign sim_phase_ctrl_finish_op    = finish_q;
  assign sim_phase_ctrl_cause_op     = cause_q;
  assign sim_phase_ctrl_state_op     = state_q;

endmodule

// File: tb/tb_sim_phase_ctrl.sv
// Bench for sim_phase_ctrl: a cycle-level behavioural model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_sim_phase_ctrl;

  localparam int RST_BASE = 5;
  localparam int STAG     = 2;
  localparam int NR       = 4;
  localparam int TICK     = 20;
  localparam int IDLE     = 8;
  localparam int DMAX     = 16;
  localparam int LAST_REL = RST_BASE + (NR - 1) * STAG;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst_n_s = 1'b0;
  logic        cfg_we = 1'b0;
  logic [31:0] cfg_timeout = '0;
  logic        activity = 1'b0;
  logic        finish_req = 1'b0;
  logic        drain_ack = 1'b0;

  logic [3:0]  rst_o;
  logic [31:0] cycles_o;
  logic        tick_o, drain_o, finish_o;
  logic [1:0]  cause_o, state_o;

  logic [3:0]  s_rst;
  logic [3:0]  s_cycles;
  logic        s_tick, s_drain, s_finish;
  logic [1:0]  s_cause, s_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sim_phase_ctrl #(
    .CNT_W(32), .N_RST(NR), .RST_BASE(RST_BASE), .RST_STAGGER(STAG),
    .TIMEOUT_INIT(10), .TICK_FREQ(TICK), .IDLE_LIMIT(IDLE), .DRAIN_MAX(DMAX)
  ) dut (
    .sim_phase_ctrl_clk_ip         (clk),
    .sim_phase_ctrl_rst_n_ip       (rst_n),
    .sim_phase_ctrl_cfg_we_ip      (cfg_we),
    .sim_phase_ctrl_cfg_timeout_ip (cfg_timeout),
    .sim_phase_ctrl_activity_ip    (activity),
    .sim_phase_ctrl_finish_req_ip  (finish_req),
    .sim_phase_ctrl_drain_ack_ip   (drain_ack),
    .sim_phase_ctrl_rst_op         (rst_o),
    .sim_phase_ctrl_cycles_op      (cycles_o),
    .sim_phase_ctrl_tick_op        (tick_o),
    .sim_phase_ctrl_drain_req_op   (drain_o),
    .sim_phase_ctrl_finish_op      (finish_o),
    .sim_phase_ctrl_cause_op       (cause_o),
    .sim_phase_ctrl_state_op       (state_o)
  );

  // Narrow counter instance: saturation must stop the timeout from firing.
  sim_phase_ctrl #(
    .CNT_W(4), .N_RST(4), .RST_BASE(5), .RST_STAGGER(2),
    .TIMEOUT_INIT(15), .TICK_FREQ(1000), .IDLE_LIMIT(0), .DRAIN_MAX(16)
  ) dut_small (
    .sim_phase_ctrl_clk_ip         (clk),
    .sim_phase_ctrl_rst_n_ip       (rst_n_s),
    .sim_phase_ctrl_cfg_we_ip      (1'b0),
    .sim_phase_ctrl_cfg_timeout_ip (4'd0),
    .sim_phase_ctrl_activity_ip    (1'b0),
    .sim_phase_ctrl_finish_req_ip  (1'b0),
    .sim_phase_ctrl_drain_ack_ip   (1'b1),
    .sim_phase_ctrl_rst_op         (s_rst),
    .sim_phase_ctrl_cycles_op      (s_cycles),
    .sim_phase_ctrl_tick_op        (s_tick),
    .sim_phase_ctrl_drain_req_op   (s_drain),
    .sim_phase_ctrl_finish_op      (s_finish),
    .sim_phase_ctrl_cause_op       (s_cause),
    .sim_phase_ctrl_state_op       (s_state)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 reset, 1 run, 2 drain, 3 done.
  longint m_cycles  = 0;
  longint m_timeout = 10;
  int     m_state   = 0;
  int     m_cause   = 0;
  int     m_idle    = 0;
  int     m_drain   = 0;
  int     m_ns;

  function automatic longint exp_rst(input longint c);
    longint r;
    r = 0;
    for (int i = 0; i < NR; i++)
      if (c < longint'(RST_BASE + i * STAG)) r = r | (longint'(1) << i);
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cycles = 0; m_timeout = 10; m_state = 0; m_cause = 0; m_idle = 0; m_drain = 0;
      end else begin
        m_ns = m_state;
        case (m_state)
          0: if (m_cycles >= LAST_REL) m_ns = 1;
          1: begin
            if (finish_req)                    begin m_ns = 2; m_cause = 3; end
            else if (m_idle == IDLE)           begin m_ns = 2; m_cause = 2; end
            else if (m_cycles > m_timeout)     begin m_ns = 2; m_cause = 1; end
            if (m_ns == 2) m_drain = 0;
          end
          2: begin
            m_drain++;
            if (drain_ack || m_drain == DMAX) m_ns = 3;
          end
          default: ;
        endcase
        if (cfg_we && (m_state == 0 || m_state == 1)) m_timeout = longint'(cfg_timeout);
        if (activity || m_state == 0) m_idle = 0;
        else if (m_state == 1 && m_idle < IDLE) m_idle++;
        if (m_cycles < 64'hFFFF_FFFF) m_cycles++;
        m_state = m_ns;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_rst",    longint'(rst_o),    exp_rst(m_cycles));
      check("cyc_cycles", longint'(cycles_o), m_cycles);
      check("cyc_tick",   longint'(tick_o),   longint'(m_cycles != 0 && (m_cycles % TICK) == 0));
      check("cyc_drain",  longint'(drain_o),  longint'(m_state == 2));
      check("cyc_finish", longint'(finish_o), longint'(m_state == 3));
      check("cyc_cause",  longint'(cause_o),  longint'(m_cause));
      check("cyc_state",  longint'(state_o),  longint'(m_state));
    end
  end

  task automatic wait_cyc(input longint v, input string tag);
    int n;
    n = 0;
    while (longint'(cycles_o) != v && n < 500) begin
      @(negedge clk);
      n++;
    end
    check(tag, longint'(cycles_o), v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    cfg_we = 1'b0; cfg_timeout = '0; activity = 1'b0; finish_req = 1'b0; drain_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic write_timeout(input logic [31:0] v);
    cfg_timeout = v;
    cfg_we = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rst_n_s = 1'b1;

    // Defaults, ack tied high: timeout fires on the first RUN cycle.
    drain_ack = 1'b1;
    wait_cyc(1, "s1_first_cycle");
    check("s1_rst_at1", longint'(rst_o), 15);
    wait_cyc(7, "s1_cyc7");
    check("s1_rst_at7", longint'(rst_o), 12);
    wait_cyc(11, "s1_cyc11");
    check("s1_rst_at11", longint'(rst_o), 0);
    check("s1_state_at11", longint'(state_o), 0);
    wait_cyc(12, "s1_cyc12");
    check("s1_run", longint'(state_o), 1);
    wait_cyc(13, "s1_cyc13");
    check("s1_drain", longint'(drain_o), 1);
    check("s1_cause", longint'(cause_o), 1);
    wait_cyc(14, "s1_cyc14");
    check("s1_finish", longint'(finish_o), 1);
    check("s1_done_drain_low", longint'(drain_o), 0);
    wait_cyc(20, "s1_cyc20");
    check("s1_tick20", longint'(tick_o), 1);

    // Timeout rewritten to 50, watchdog kept alive, ack held low.
    do_reset();
    wait_cyc(3, "s2_cyc3");
    write_timeout(32'd50);
    n = 0;
    while (cycles_o < 51 && n < 200) begin
      activity  = (cycles_o[1:0] == 2'b00);
      drain_ack = (cycles_o == 30);
      @(negedge clk);
      n++;
    end
    activity = 1'b0; drain_ack = 1'b0;
    check("s2_cyc51", longint'(cycles_o), 51);
    check("s2_still_run", longint'(state_o), 1);
    @(negedge clk);
    check("s2_drain52", longint'(drain_o), 1);
    check("s2_cause", longint'(cause_o), 1);
    cfg_timeout = 32'd5; cfg_we = 1'b1; finish_req = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; finish_req = 1'b0;
    check("s2_cause_kept", longint'(cause_o), 1);
    wait_cyc(67, "s2_cyc67");
    check("s2_drain67", longint'(drain_o), 1);
    check("s2_nofinish67", longint'(finish_o), 0);
    wait_cyc(68, "s2_cyc68");
    check("s2_finish68", longint'(finish_o), 1);
    check("s2_state68", longint'(state_o), 3);

    // Watchdog: activity every 5 cycles up to 40, then silence.
    do_reset();
    drain_ack = 1'b1;
    wait_cyc(2, "s3_cyc2");
    write_timeout(32'd1000);
    n = 0;
    while (cycles_o < 49 && n < 200) begin
      activity = (cycles_o % 5 == 0) && (cycles_o <= 40);
      @(negedge clk);
      n++;
    end
    activity = 1'b0;
    check("s3_run49", longint'(state_o), 1);
    @(negedge clk);
    check("s3_cyc50", longint'(cycles_o), 50);
    check("s3_drain50", longint'(drain_o), 1);
    check("s3_cause", longint'(cause_o), 2);

    // External request on the same edge as watchdog expiry.
    do_reset();
    drain_ack = 1'b1;
    wait_cyc(2, "s4_cyc2");
    write_timeout(32'd1000);
    wait_cyc(20, "s4_cyc20");
    check("s4_run20", longint'(state_o), 1);
    finish_req = 1'b1;
    @(negedge clk);
    finish_req = 1'b0;
    check("s4_drain21", longint'(drain_o), 1);
    check("s4_cause_ext", longint'(cause_o), 3);

    // Asynchronous reset in the middle of DRAIN.
    do_reset();
    wait_cyc(16, "s5_cyc16");
    check("s5_in_drain", longint'(state_o), 2);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_rst",    longint'(rst_o),    15);
    check("s5_rst_cycles", longint'(cycles_o), 0);
    check("s5_rst_tick",   longint'(tick_o),   0);
    check("s5_rst_drain",  longint'(drain_o),  0);
    check("s5_rst_finish", longint'(finish_o), 0);
    check("s5_rst_cause",  longint'(cause_o),  0);
    check("s5_rst_state",  longint'(state_o),  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("s5_restart_cycles", longint'(cycles_o), 1);
    check("s5_restart_state",  longint'(state_o),  0);

    // Narrow counter has long since saturated.
    check("sm_cycles_sat", longint'(s_cycles), 15);
    check("sm_state_run",  longint'(s_state),  1);
    check("sm_no_finish",  longint'(s_finish), 0);
    check("sm_no_drain",   longint'(s_drain),  0);
    check("sm_rst_low",    longint'(s_rst),    0);
    check("sm_cause_none", longint'(s_cause),  0);
    check("sm_no_tick",    longint'(s_tick),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got timeout, expected completion");
    $fatal(1, "time limit");
  end

endmodule
